// File: rtl/asmd_pkg.sv
// Shared types and helpers for the ASMD shift-add multiplier.
package asmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TEST  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_FIX   = 3'd4
  } state_t;

  // Widest operand the absolute-value helper can handle.
  localparam int unsigned ABS_MAX_W = 64;

  // Conditional absolute value of a width-bit value held zero-extended in
  // a 64-bit container. When en=0 the value passes through unchanged.
  // |-2^(width-1)| yields 2^(width-1), which is representable unsigned.
  function automatic logic [ABS_MAX_W-1:0] cond_abs(
    input logic [ABS_MAX_W-1:0] value,
    input int unsigned          width,
    input logic                 en
  );
    logic [ABS_MAX_W-1:0] mask;
    mask = (ABS_MAX_W'(1) << width) - ABS_MAX_W'(1);
    if (en && value[6'(width - 1)])
      cond_abs = (~value + ABS_MAX_W'(1)) & mask;
    else
      cond_abs = value & mask;
  endfunction

endpackage

// File: rtl/asmd_mult_datapath.sv
// Datapath of the ASMD multiplier: operand/accumulator/product registers,
// adder and sign fix-up, driven by one-hot-style control strobes.
module asmd_mult_datapath
  import asmd_pkg::*;
#(
  parameter int word_length = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       add,
  input  logic                       shift,
  input  logic                       fix,
  input  logic [word_length-1:0]     word0,
  input  logic [word_length-1:0]     word1,
  input  logic                       signed_mode,
  input  logic                       accumulate,
  output logic [2*word_length-1:0]   product,
  output logic                       mplier_zero,
  output logic                       mplier_lsb
);

  logic [2*word_length-1:0] mcand;
  logic [word_length-1:0]   mplier;
  logic [2*word_length-1:0] acc;
  logic                     neg;
  logic                     acc_mode;

  logic [word_length-1:0]   abs0;
  logic [word_length-1:0]   abs1;
  logic [2*word_length-1:0] fix_val;

  assign abs0 = word_length'(cond_abs(ABS_MAX_W'(word0), word_length, signed_mode));
  assign abs1 = word_length'(cond_abs(ABS_MAX_W'(word1), word_length, signed_mode));

  assign fix_val     = neg ? (-acc) : acc;
  assign mplier_zero = (mplier == '0);
  assign mplier_lsb  = mplier[0];

  // Operand load, accumulate, shift and final signed/accumulating write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      acc_mode <= 1'b0;
      product  <= '0;
    end else if (load) begin
      mcand    <= {{word_length{1'b0}}, abs0};
      mplier   <= abs1;
      acc      <= '0;
      neg      <= signed_mode & (word0[word_length-1] ^ word1[word_length-1]);
      acc_mode <= accumulate;
    end else if (add) begin
      acc <= acc + mcand;
    end else if (shift) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end else if (fix) begin
      product <= acc_mode ? (product + fix_val) : fix_val;
    end
  end

endmodule

// File: rtl/asmd_seq_multiplier.sv
// ASMD sequential shift-add multiplier: controller FSM with registered
// ready level and one-cycle done pulse; arithmetic lives in the datapath.
module asmd_seq_multiplier
  import asmd_pkg::*;
#(
  parameter int word_length = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [word_length-1:0]   word0,
  input  logic [word_length-1:0]   word1,
  input  logic                     start,
  input  logic                     signed_mode,
  input  logic                     accumulate,
  output logic [2*word_length-1:0] product,
  output logic                     ready,
  output logic                     done
);

  state_t state;
  logic   load;
  logic   mplier_zero;
  logic   mplier_lsb;

  assign load = (state == S_IDLE) & start;

  asmd_mult_datapath #(
    .word_length(word_length)
  ) u_datapath (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .add         (state == S_ADD),
    .shift       (state == S_SHIFT),
    .fix         (state == S_FIX),
    .word0       (word0),
    .word1       (word1),
    .signed_mode (signed_mode),
    .accumulate  (accumulate),
    .product     (product),
    .mplier_zero (mplier_zero),
    .mplier_lsb  (mplier_lsb)
  );

  // Controller: sequences test/add/shift until the multiplier is exhausted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_TEST;
            ready <= 1'b0;
          end
        end
        S_TEST: begin
          if (mplier_zero)     state <= S_FIX;
          else if (mplier_lsb) state <= S_ADD;
          else                 state <= S_SHIFT;
        end
        S_ADD:   state <= S_SHIFT;
        S_SHIFT: state <= S_TEST;
        S_FIX: begin
          state <= S_IDLE;
          ready <= 1'b1;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asmd_seq_multiplier.sv
// Scoreboard bench for asmd_seq_multiplier (W=4): stimulus pushes expected
// product and latency, an independent monitor checks each done pulse.
module tb_asmd_seq_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   word0;
  logic [W-1:0]   word1;
  logic           start;
  logic           signed_mode;
  logic           accumulate;
  logic [2*W-1:0] product;
  logic           ready;
  logic           done;

  asmd_seq_multiplier #(
    .word_length(W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .word0       (word0),
    .word1       (word1),
    .start       (start),
    .signed_mode (signed_mode),
    .accumulate  (accumulate),
    .product     (product),
    .ready       (ready),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] prod;
    int unsigned    acc_cyc;
    int unsigned    lat;
  } exp_t;

  exp_t           sb[$];
  exp_t           mon_e;
  int unsigned    cyc = 0;
  int             n_checks = 0;
  int             n_pass = 0;
  logic [2*W-1:0] model_prod = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, expv);
  endtask

  // Reference: plain integer multiplication of the interpreted operands.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sm);
    int p;
    if (sm) p = int'($signed(a)) * int'($signed(b));
    else    p = int'(a) * int'(b);
    return (2*W)'(p);
  endfunction

  // Reference latency from the magnitude of the multiplier.
  function automatic int unsigned ref_lat(input logic [W-1:0] b, input logic sm);
    int mag;
    int h;
    int pop;
    mag = sm ? ((int'($signed(b)) < 0) ? -int'($signed(b)) : int'($signed(b))) : int'(b);
    if (mag == 0) return 2;
    h = 0;
    pop = 0;
    for (int i = 0; i < W; i++) begin
      if (((mag >> i) & 1) == 1) begin
        h = i;
        pop++;
      end
    end
    return int'(2 * (h + 1) + pop + 2);
  endfunction

  task automatic scramble();
    word0       = W'($urandom);
    word1       = W'($urandom);
    signed_mode = 1'($urandom);
    accumulate  = 1'($urandom);
  endtask

  // Issue one operation at a negedge once ready; use_k selects a fixed
  // expected product instead of the arithmetic model.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                       input logic ac, input logic use_k, input logic [2*W-1:0] k);
    int   t;
    exp_t e;
    logic [2*W-1:0] r;
    t = 0;
    while (!ready && t < 100) begin
      scramble();
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      n_checks++;
      $display("FAIL ready_timeout: got ready=0 required ready=1 within 100 cycles");
      return;
    end
    word0       = a;
    word1       = b;
    signed_mode = sm;
    accumulate  = ac;
    start       = 1'b1;
    r = ref_mul(a, b, sm);
    model_prod = ac ? (model_prod + r) : r;
    if (use_k) model_prod = k;
    e.prod    = model_prod;
    e.acc_cyc = cyc + 1;
    e.lat     = ref_lat(b, sm);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    scramble();
  endtask

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 required no pending operation");
      end else begin
        mon_e = sb.pop_front();
        check("product", 32'(product), 32'(mon_e.prod));
        check("latency", cyc - mon_e.acc_cyc, mon_e.lat);
        check("ready_with_done", 32'(ready), 32'd1);
      end
    end
  end

  initial begin
    int t;
    reset = 1'b1;
    start = 1'b0;
    word0 = '0;
    word1 = '0;
    signed_mode = 1'b0;
    accumulate  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_product", 32'(product), 32'h0);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases with fixed expected products.
    issue(4'd3, 4'd5, 1'b0, 1'b0, 1'b1, 8'h0F);
    issue(4'h8, 4'h7, 1'b1, 1'b0, 1'b1, 8'hC8);
    issue(4'h8, 4'h8, 1'b1, 1'b0, 1'b1, 8'h40);
    issue(4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 8'hE1);
    issue(4'd3, 4'd5, 1'b0, 1'b1, 1'b1, 8'hF0);
    issue(4'd4, 4'd4, 1'b0, 1'b1, 1'b1, 8'h00);
    issue(4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 8'h00);
    issue(4'h0, 4'hB, 1'b1, 1'b0, 1'b1, 8'h00);

    // Reset in the middle of 15*15 abandons it and clears product.
    issue(4'hF, 4'hF, 1'b0, 1'b0, 1'b0, '0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_product", 32'(product), 32'h0);
    check("midreset_ready", 32'(ready), 32'd1);
    check("midreset_done", 32'(done), 32'd0);
    sb.delete();
    model_prod = '0;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    issue(4'd2, 4'd3, 1'b0, 1'b0, 1'b1, 8'h06);

    // Start held high: one result per ready window, back-to-back accepts.
    t = 0;
    while (!ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (ready) begin
        exp_t e;
        word0 = 4'd2;
        word1 = 4'd3;
        signed_mode = 1'b0;
        accumulate  = 1'b0;
        model_prod  = 8'h06;
        e.prod    = 8'h06;
        e.acc_cyc = cyc + 1;
        e.lat     = ref_lat(4'd3, 1'b0);
        sb.push_back(e);
      end else begin
        scramble();
      end
      @(negedge clk);
    end
    start = 1'b0;

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 150; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
            1'b0, '0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
